// File: rtl/controller_sysid_checker_if.sv
// Avalon-MM read bus between the sysid checker (master) and the system-ID slave.
// Carries address/read from the master and readdata/waitrequest back from the slave.
interface controller_sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata,
    output avm_waitrequest
  );
endinterface

// File: rtl/controller_sysid_checker.sv
// Reads sysid ID (addr 0) then timestamp (addr 1), compares them with build-time values; done after 2*(1+READ_LATENCY)+1 cycles.
// Requests are held stable while waitrequest stalls; each read is bounded by TIMEOUT_CYCLES, so the sequence always terminates.
module controller_sysid_checker #(
  parameter logic [31:0] EXP_ID         = 32'h0000C001,
  parameter logic [31:0] EXP_TS         = 32'h5BB95C52,
  parameter int          READ_LATENCY   = 1,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  controller_sysid_checker_if.master        bus,
  output logic [31:0]                       id_value,
  output logic [31:0]                       ts_value,
  output logic                              id_match,
  output logic                              ts_match,
  output logic                              busy,
  output logic                              done,
  output logic                              timeout
);

  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]     LAT_LAST = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
  localparam bit             ZERO_LAT = (READ_LATENCY == 0);

  typedef enum logic [2:0] {
    S_IDLE, S_ID_REQ, S_ID_WAIT, S_TS_REQ, S_TS_WAIT, S_DONE, S_ERR
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_tcnt;
  logic [1:0]    r_lcnt;
  logic          r_auto;
  logic          r_id_cap;
  logic [31:0]   r_id_value;
  logic [31:0]   r_ts_value;
  logic          r_id_match;
  logic          r_ts_match;
  logic          w_cap_id;
  logic          w_cap_ts;
  logic          w_tmo_hit;
  logic          w_active;
  logic          w_enter_req;

  assign w_tmo_hit = (r_tcnt == TMO_LAST);
  assign w_active  = (r_state == S_ID_REQ) || (r_state == S_ID_WAIT) ||
                     (r_state == S_TS_REQ) || (r_state == S_TS_WAIT);
  assign w_enter_req = (w_next != r_state) && ((w_next == S_ID_REQ) || (w_next == S_TS_REQ));

  // Capture wins over timeout when both land on the same edge.
  always_comb begin
    w_next   = r_state;
    w_cap_id = 1'b0;
    w_cap_ts = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start || r_auto) w_next = S_ID_REQ;
      end
      S_ID_REQ: begin
        if (!bus.avm_waitrequest) begin
          if (ZERO_LAT) begin
            w_cap_id = 1'b1;
            w_next   = S_TS_REQ;
          end else begin
            w_next   = S_ID_WAIT;
          end
        end else if (w_tmo_hit) begin
          w_next = S_ERR;
        end
      end
      S_ID_WAIT: begin
        if (r_lcnt == LAT_LAST) begin
          w_cap_id = 1'b1;
          w_next   = S_TS_REQ;
        end else if (w_tmo_hit) begin
          w_next = S_ERR;
        end
      end
      S_TS_REQ: begin
        if (!bus.avm_waitrequest) begin
          if (ZERO_LAT) begin
            w_cap_ts = 1'b1;
            w_next   = S_DONE;
          end else begin
            w_next   = S_TS_WAIT;
          end
        end else if (w_tmo_hit) begin
          w_next = S_ERR;
        end
      end
      S_TS_WAIT: begin
        if (r_lcnt == LAT_LAST) begin
          w_cap_ts = 1'b1;
          w_next   = S_DONE;
        end else if (w_tmo_hit) begin
          w_next = S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        if (start) w_next = S_ID_REQ;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_auto     <= AUTO_START;
      r_tcnt     <= '0;
      r_lcnt     <= '0;
      r_id_cap   <= 1'b0;
      r_id_value <= '0;
      r_ts_value <= '0;
      r_id_match <= 1'b0;
      r_ts_match <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_auto   <= 1'b0;
      r_id_cap <= w_cap_id;

      if (w_enter_req)   r_tcnt <= '0;
      else if (w_active) r_tcnt <= r_tcnt + 1'b1;

      if ((r_state == S_ID_WAIT) || (r_state == S_TS_WAIT)) r_lcnt <= r_lcnt + 1'b1;
      else                                                  r_lcnt <= '0;

      if ((w_next == S_ID_REQ) && (r_state != S_ID_REQ)) begin
        r_id_value <= '0;
        r_ts_value <= '0;
        r_id_match <= 1'b0;
        r_ts_match <= 1'b0;
      end else begin
        if (w_cap_id) r_id_value <= bus.avm_readdata;
        if (r_id_cap) r_id_match <= (r_id_value == EXP_ID);
        if (w_cap_ts) begin
          r_ts_value <= bus.avm_readdata;
          r_ts_match <= (bus.avm_readdata == EXP_TS);
        end
      end
    end
  end

  assign bus.avm_read    = (r_state == S_ID_REQ) || (r_state == S_TS_REQ);
  assign bus.avm_address = (r_state == S_TS_REQ);
  assign id_value        = r_id_value;
  assign ts_value        = r_ts_value;
  assign id_match        = r_id_match;
  assign ts_match        = r_ts_match;
  assign busy            = w_active;
  assign done            = (r_state == S_DONE) || (r_state == S_ERR);
  assign timeout         = (r_state == S_ERR);

endmodule

// File: tb/tb_controller_sysid_checker.sv
// Bench for controller_sysid_checker: behavioural Avalon slave, reference model and done-triggered scoreboard.
module tb_controller_sysid_checker;
  localparam logic [31:0] EXP_ID = 32'h0000C001;
  localparam logic [31:0] EXP_TS = 32'h5BB95C52;
  localparam int RL  = 1;
  localparam int TMO = 8;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] id_value, ts_value;
  logic        id_match, ts_match, busy, done, timeout;

  controller_sysid_checker_if bus ();

  controller_sysid_checker #(
    .EXP_ID(EXP_ID), .EXP_TS(EXP_TS), .READ_LATENCY(RL),
    .TIMEOUT_CYCLES(TMO), .AUTO_START(1'b1)
  ) dut (
    .clock(clk), .reset(reset), .start(start), .bus(bus),
    .id_value(id_value), .ts_value(ts_value), .id_match(id_match),
    .ts_match(ts_match), .busy(busy), .done(done), .timeout(timeout)
  );

  typedef struct {
    int unsigned start_cyc;
    int unsigned lat;
    logic [31:0] id;
    logic [31:0] ts;
    logic        idm;
    logic        tsm;
    logic        tmo;
    int          nreads;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [31:0] mem [2];
  int          cfg_stall [2];
  bit          cfg_stuck [2];
  int          acc_log [$];
  exp_t        sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: one read costs request + stall + latency cycles; a stuck read costs TMO then ERR.
  function automatic exp_t model(input int unsigned sc, input logic [31:0] m0, input logic [31:0] m1,
                                 input int s0, input int s1, input bit k0, input bit k1);
    exp_t e;
    e.start_cyc = sc;
    e.id = 0; e.ts = 0; e.idm = 0; e.tsm = 0; e.tmo = 0; e.nreads = 0;
    if (k0) begin
      e.tmo = 1; e.lat = TMO + 1;
    end else begin
      e.id = m0; e.idm = (m0 == EXP_ID); e.nreads = 1;
      if (k1) begin
        e.tmo = 1; e.lat = (1 + s0 + RL) + TMO + 1;
      end else begin
        e.ts = m1; e.tsm = (m1 == EXP_TS); e.nreads = 2;
        e.lat = (1 + s0 + RL) + (1 + s1 + RL) + 1;
      end
    end
    return e;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Slave: decides waitrequest at the negedge, returns data one cycle after acceptance, garbage otherwise.
  bit   in_req = 0, acc_prev = 0, prev_wr = 0;
  logic pend_addr = 0, prev_addr = 0;
  int   stall_left = 0;
  initial begin
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = '0;
    forever begin
      @(negedge clk);
      bus.avm_readdata = acc_prev ? mem[pend_addr] : $urandom;
      acc_prev = 0;
      if (prev_wr && !reset && !timeout)
        chk("stall_hold", 32'({bus.avm_read, bus.avm_address}), 32'({1'b1, prev_addr}));
      if (bus.avm_read === 1'b1) begin
        if (!in_req) begin
          in_req = 1;
          stall_left = cfg_stall[bus.avm_address];
        end
        if (cfg_stuck[bus.avm_address] || stall_left > 0) begin
          bus.avm_waitrequest = 1'b1;
          if (stall_left > 0) stall_left--;
        end else begin
          bus.avm_waitrequest = 1'b0;
          acc_prev  = 1;
          pend_addr = bus.avm_address;
          in_req    = 0;
          acc_log.push_back(int'(bus.avm_address));
        end
      end else begin
        bus.avm_waitrequest = 1'b0;
        in_req = 0;
      end
      prev_wr   = bus.avm_waitrequest && (bus.avm_read === 1'b1);
      prev_addr = bus.avm_address;
    end
  end

  // Monitor: every rising edge of done retires one expected sequence.
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && done_prev !== 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow done rose at cycle %0d with no expected sequence", cyc);
        end else begin
          e = sb.pop_front();
          chk("latency",  32'(cyc - e.start_cyc), 32'(e.lat));
          chk("id_value", id_value, e.id);
          chk("ts_value", ts_value, e.ts);
          chk("flags", 32'({id_match, ts_match, timeout, busy, bus.avm_read}),
                       32'({e.idm, e.tsm, e.tmo, 1'b0, 1'b0}));
          chk("nreads", 32'(acc_log.size()), 32'(e.nreads));
          if (acc_log.size() == e.nreads)
            for (int i = 0; i < e.nreads; i++) chk("read_addr", 32'(acc_log[i]), 32'(i));
        end
        acc_log.delete();
      end
      done_prev = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_cfg(input logic [31:0] m0, input logic [31:0] m1, input int s0, input int s1,
                         input bit k0, input bit k1);
    mem[0] = m0; mem[1] = m1;
    cfg_stall[0] = s0; cfg_stall[1] = s1;
    cfg_stuck[0] = k0; cfg_stuck[1] = k1;
  endtask

  task automatic issue();
    sb.push_back(model(cyc, mem[0], mem[1], cfg_stall[0], cfg_stall[1], cfg_stuck[0], cfg_stuck[1]));
    pulse_start();
    chk("start_clear", 32'({busy, done, timeout, id_match, ts_match, bus.avm_read, bus.avm_address}),
                       32'(7'b1000010));
    chk("start_clear_vals", id_value | ts_value, 32'h0);
  endtask

  task automatic do_reset(input int cycles, input bit with_start);
    reset = 1'b1;
    start = with_start;
    tick();
    acc_log.delete();
    start = 1'b0;
    chk("reset_flags", 32'({id_match, ts_match, busy, done, timeout, bus.avm_read, bus.avm_address}), 32'h0);
    chk("reset_id", id_value, 32'h0);
    chk("reset_ts", ts_value, 32'h0);
    for (int i = 1; i < cycles; i++) tick();
    reset = 1'b0;
    sb.push_back(model(cyc, mem[0], mem[1], cfg_stall[0], cfg_stall[1], cfg_stuck[0], cfg_stuck[1]));
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_done done=%b after %0d cycles", done, n);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    set_cfg(EXP_ID, EXP_TS, 0, 0, 0, 0);

    // Auto-start after reset, with a start pulse coincident with reset.
    do_reset(2, 1'b1);
    wait_done(100);

    set_cfg(32'h0000C002, EXP_TS, 0, 0, 0, 0);
    issue();
    wait_done(100);

    set_cfg(EXP_ID, EXP_TS, 3, 3, 0, 0);
    issue();
    wait_done(100);

    set_cfg(EXP_ID, EXP_TS, 0, 0, 1, 0);
    issue();
    wait_done(100);

    set_cfg(EXP_ID, EXP_TS, 1, 0, 0, 1);
    issue();
    wait_done(100);

    // Reset while the timestamp read is outstanding, then ignored starts while busy.
    set_cfg(EXP_ID, EXP_TS, 0, 0, 0, 0);
    pulse_start();
    tick();
    tick();
    tick();
    chk("in_ts_wait", 32'({busy, bus.avm_read, id_value == EXP_ID}), 32'(3'b101));
    do_reset(2, 1'b1);
    tick();
    pulse_start();
    chk("busy_ignore", 32'(busy), 32'h1);
    pulse_start();
    wait_done(100);

    set_cfg(EXP_ID, 32'h12345678, 0, 0, 0, 0);
    issue();
    wait_done(100);

    for (int it = 0; it < 30; it++) begin
      int r;
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      r = $urandom_range(0, 9);
      set_cfg(($urandom_range(0, 3) == 0) ? 32'($urandom) : EXP_ID,
              ($urandom_range(0, 3) == 0) ? 32'($urandom) : EXP_TS,
              $urandom_range(0, 5), $urandom_range(0, 5), r == 0, r == 1);
      issue();
      wait_done(100);
    end

    tick();
    tick();
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/controller_sysid_checker.md
Name: controller_sysid_checker

Overview:
- Avalon-MM read master that sits directly downstream of the system-ID slave and consumes its control_slave read data.
- After reset, or on request, it reads the ID word (address 0) and then the timestamp word (address 1), and captures both.
- It compares each word against build-time expected values and exposes the match and status flags to the controller's boot/health logic.
- A per-read timeout guarantees the block always reaches a terminal state.

Parameters:
- EXP_ID, 32'h0000C001, expected system ID word (address 0).
- EXP_TS, 32'h5BB95C52, expected timestamp word (address 1).
- READ_LATENCY, 1, cycles from read acceptance to valid readdata; legal range 0..3.
- TIMEOUT_CYCLES, 255, maximum cycles per read from first request cycle to data capture; minimum 4.
- AUTO_START, 1, when 1 a check sequence starts automatically on the first cycle after reset deasserts.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse requesting a check sequence.
- avm_address  output  1  slave word address: 0 = ID, 1 = timestamp.
- avm_read  output  1  read request.
- avm_readdata  input  32  slave read data.
- avm_waitrequest  input  1  slave stall; tie to 0 for a zero-wait slave.
- id_value  output  32  captured ID word.
- ts_value  output  32  captured timestamp word.
- id_match  output  1  id_value == EXP_ID.
- ts_match  output  1  ts_value == EXP_TS.
- busy  output  1  sequence in progress.
- done  output  1  sequence finished (success, mismatch, or timeout); level signal.
- timeout  output  1  a read exceeded TIMEOUT_CYCLES.

Behaviour:
- Reset (synchronous, active-high): at the clock edge where reset=1 every output goes to 0.
  - id_value = ts_value = 0; flags = 0; avm_read = 0; avm_address = 0.
  - FSM enters IDLE; latency and timeout counters clear.
- Reset asserted mid-sequence aborts it at that edge. No partial flags are retained.
- FSM states: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, DONE, ERR.
- IDLE transitions:
  - Go to ID_REQ on start=1.
  - If AUTO_START=1, also go to ID_REQ on the first cycle after reset deasserts (one time only per reset).
- Entering ID_REQ:
  - Clears id_value, ts_value, id_match, ts_match, done and timeout.
  - Drives avm_read=1, avm_address=0; busy=1.
- Request handshake: avm_read and avm_address stay stable until an edge where avm_waitrequest=0. That edge is acceptance.
  - avm_read deasserts on the next cycle unless the next state issues a new request.
- Data capture, ID read:
  - READ_LATENCY=0: avm_readdata is captured at the acceptance edge; the FSM goes directly to TS_REQ.
  - READ_LATENCY>0: the FSM enters ID_WAIT, counts READ_LATENCY cycles, captures avm_readdata, then goes to TS_REQ.
- Timestamp read: TS_REQ and TS_WAIT mirror the ID states with avm_address=1. After capture the FSM enters DONE.
- Match flags:
  - id_match is registered one cycle after id_value is captured.
  - ts_match is registered in the same cycle that DONE is entered, so both flags are valid whenever done=1.
- DONE: busy=0, done=1. Values and flags hold until the next start or reset. start=1 goes to ID_REQ (restart).
- Timeout counter:
  - Cleared on entry to each REQ state and increments every cycle in REQ/WAIT.
  - If it reaches TIMEOUT_CYCLES before capture, the FSM enters ERR with avm_read=0, timeout=1, done=1, busy=0.
  - Already-captured values are kept; the match flag of the uncaptured word stays 0.
- ERR: behaves like DONE; start=1 restarts.
- start while busy=1 is ignored.
- start coincident with reset: reset wins; no sequence starts.
- Nominal latency, start pulse to done, with waitrequest=0:
  - READ_LATENCY=1: ID_REQ 1 + ID_WAIT 1 + TS_REQ 1 + TS_WAIT 1 = done asserted 5 cycles after start is sampled.
  - General: 2×(1+READ_LATENCY)+1 cycles.

Test Plan:
- Zero-wait slave returns 0x0000C001 at address 0 and 0x5BB95C52 at address 1 (READ_LATENCY=1), reset released -> auto-start; done=1 5 cycles after reset deasserts; id_match=1, ts_match=1, timeout=0, reads issued at address 0 then 1.
- Slave returns ID 0x0000C002 -> done=1, id_match=0, ts_match=1, id_value=0x0000C002.
- avm_waitrequest held high 3 cycles on each read -> avm_read and avm_address stable throughout the stall; done 6 cycles later than the zero-wait case; both matches=1.
- avm_waitrequest stuck high, TIMEOUT_CYCLES=8 -> ERR 8 cycles after ID_REQ entry; timeout=1, done=1, busy=0, avm_read=0, id_match=0.
- reset pulsed while in TS_WAIT -> all outputs 0 at that edge; after release the sequence re-runs from address 0; start pulses during busy=1 are ignored (exactly one read per address).
- After DONE, slave timestamp changed to 0x12345678, then start pulsed -> flags clear on the first cycle; ts_match=0, ts_value=0x12345678, id_match=1.
